// File: rtl/pipearch_common_pkg.sv
// Shared definitions for the pipearch read path: streamer FSM encoding,
// cache-line width and a saturating counter helper.
package pipearch_common_pkg;

    localparam int LINE_W  = 512;
    localparam int MDATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_rd_streamer_state;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipearch_line_fifo.sv
// First-word-fall-through line buffer with occupancy count; push and pop may
// coincide at any fill level, including full.
module pipearch_line_fifo #(
    parameter int WIDTH      = 528,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A push into a full buffer is only safe when the head slot frees this cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && w_full && !i_pop));

endmodule

// File: rtl/pipearch_rd_streamer.sv
// Streams a contiguous run of cache lines from CCI-P c0 into a line buffer.
// Define PIPEARCH_RD_STATS_EN to build the issue/stall statistics counters.
module pipearch_rd_streamer
    import pipearch_common_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 6,
    parameter int ADDR_W          = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       num_lines,
    output logic              busy,
    output logic              done,
    output logic              c0tx_valid,
    output logic [ADDR_W-1:0] c0tx_addr,
    output logic [15:0]       c0tx_mdata,
    input  logic              c0tx_almfull,
    input  logic              c0rx_valid,
    input  logic [15:0]       c0rx_mdata,
    input  logic [LINE_W-1:0] c0rx_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic [15:0]       out_idx,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 2;

    t_rd_streamer_state           r_state;
    logic [ADDR_W-1:0]            r_base;
    logic [31:0]                  r_num;
    logic [31:0]                  r_idx;
    logic [FIFO_DEPTH_LOG2:0]     r_inflight;
    logic                         r_done;
    logic                         r_c0tx_valid;
    logic [ADDR_W-1:0]            r_c0tx_addr;
    logic [15:0]                  r_c0tx_mdata;

    logic                         w_busy;
    logic                         w_start_ok;
    logic                         w_credit_ok;
    logic                         w_issue;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifo_valid;
    logic [FIFO_DEPTH_LOG2:0]     w_fifo_count;
    logic [LINE_W+MDATA_W-1:0]    w_fifo_dout;
    logic [CW-1:0]                w_credit_used;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_start_ok    = (r_state == ST_IDLE) && start;
    // Every outstanding request reserves a buffer slot, so responses can never overflow it.
    assign w_credit_used = CW'(r_inflight) + CW'(w_fifo_count);
    assign w_credit_ok   = (w_credit_used < CW'(DEPTH));
    assign w_issue       = (r_state == ST_ISSUE) && !c0tx_almfull && w_credit_ok;
    assign w_push        = c0rx_valid && w_busy;
    assign w_pop         = w_fifo_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= (num_lines == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_idx <= r_idx + 32'd1;
                        if (r_idx == r_num - 32'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == '0 && w_fifo_count == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_base <= base_addr;
            r_num  <= num_lines;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c0tx_valid <= 1'b0;
            r_c0tx_addr  <= '0;
            r_c0tx_mdata <= '0;
            r_inflight   <= '0;
        end else begin
            r_c0tx_valid <= w_issue;
            if (w_issue) begin
                r_c0tx_addr  <= r_base + ADDR_W'(r_idx);
                r_c0tx_mdata <= r_idx[15:0];
            end
            // Stale responses reaching an idle counter must not wrap it.
            if (w_issue && !w_push) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_issue && w_push && r_inflight != '0) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    pipearch_line_fifo #(
        .WIDTH      (LINE_W + MDATA_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_line_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({c0rx_mdata, c0rx_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

`ifdef PIPEARCH_RD_STATS_EN
    logic        w_stall;
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    assign w_stall = (r_state == ST_ISSUE) && !w_issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else if (w_start_ok) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue) begin
                r_stat_issued <= sat_inc32(r_stat_issued);
            end
            if (w_stall) begin
                r_stat_stall <= sat_inc32(r_stat_stall);
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

    assign busy       = w_busy;
    assign done       = r_done;
    assign c0tx_valid = r_c0tx_valid;
    assign c0tx_addr  = r_c0tx_addr;
    assign c0tx_mdata = r_c0tx_mdata;
    assign out_valid  = w_fifo_valid;
    assign out_data   = w_fifo_dout[LINE_W-1:0];
    assign out_idx    = w_fifo_dout[LINE_W +: MDATA_W];

endmodule

// File: tb/tb_pipearch_rd_streamer.sv
// Self-checking bench for pipearch_rd_streamer: table of transfers plus
// hand-written out-of-order, zero-length and mid-transfer reset sequences.
module tb_pipearch_rd_streamer;

    localparam int DEPTH_LOG2 = 2;
    localparam int AW         = 42;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [31:0]   num_lines;
    logic          busy;
    logic          done;
    logic          c0tx_valid;
    logic [AW-1:0] c0tx_addr;
    logic [15:0]   c0tx_mdata;
    logic          c0tx_almfull;
    logic          c0rx_valid;
    logic [15:0]   c0rx_mdata;
    logic [511:0]  c0rx_data;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  out_data;
    logic [15:0]   out_idx;
    logic [31:0]   stat_issued;
    logic [31:0]   stat_stall;

    pipearch_rd_streamer #(
        .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
        .ADDR_W          (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .busy         (busy),
        .done         (done),
        .c0tx_valid   (c0tx_valid),
        .c0tx_addr    (c0tx_addr),
        .c0tx_mdata   (c0tx_mdata),
        .c0tx_almfull (c0tx_almfull),
        .c0rx_valid   (c0rx_valid),
        .c0rx_mdata   (c0rx_mdata),
        .c0rx_data    (c0rx_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .stat_issued  (stat_issued),
        .stat_stall   (stat_stall)
    );

    typedef struct {
        logic [AW-1:0] base;
        logic [31:0]   num;
        int            lat;
        int            af_lo;
        int            af_hi;
        int            rdy_from;
        bit            rdy_rand;
        bit            restart;
        int            exp_hold;
        int            exp_stall;
    } tcase_t;

    typedef struct {
        logic [15:0] mdata;
        int          due;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            req_cnt = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_pop_cyc = 0;
    int            lat_mode = 0;
    logic [AW-1:0] exp_base = '0;
    logic          af_prev = 1'b0;
    rsp_t          rsp_q[$];
    logic [15:0]   exp_q[$];
    logic [15:0]   pop_log[$];
    tcase_t        tbl[6];
    logic [15:0]   ooo_ord[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] line_of(input logic [15:0] m);
        return {16{m, m ^ 16'h5A3C}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Request monitor and output scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0]   e;
        logic [AW-1:0] ea;
        if (c0tx_valid) begin
            ea = exp_base + AW'(req_cnt);
            chk("req_addr", 64'(c0tx_addr), 64'(ea));
            chk("req_mdata", 64'(c0tx_mdata), 64'(req_cnt[15:0]));
            chk("req_after_almfull", 64'(af_prev), 64'd0);
            if (lat_mode > 0) rsp_q.push_back('{c0tx_mdata, cyc + lat_mode});
            req_cnt++;
        end
        af_prev = c0tx_almfull;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_idx", 64'(out_idx), 64'(e));
                chk("out_data", 64'(out_data === line_of(e)), 64'd1);
            end
            pop_log.push_back(out_idx);
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Response driver: one response per cycle, expected line queued when it is accepted.
    initial begin
        rsp_t r;
        c0rx_valid = 1'b0;
        c0rx_mdata = '0;
        c0rx_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                c0rx_valid = 1'b1;
                c0rx_mdata = r.mdata;
                c0rx_data  = line_of(r.mdata);
                if (busy) exp_q.push_back(r.mdata);
            end else begin
                c0rx_valid = 1'b0;
            end
        end
    end

    task automatic clear_run(input logic [AW-1:0] b, input int lat);
        exp_base = b;
        req_cnt  = 0;
        pop_cnt  = 0;
        done_cnt = 0;
        lat_mode = lat;
        pop_log.delete();
    endtask

    task automatic run_case(input tcase_t tc, input string nm);
        int rel;
        clear_run(tc.base, tc.lat);
        @(posedge clk);
        #1;
        rel          = 0;
        start        = 1'b1;
        base_addr    = tc.base;
        num_lines    = tc.num;
        c0tx_almfull = (rel >= tc.af_lo) && (rel <= tc.af_hi);
        out_ready    = tc.rdy_rand ? 1'($urandom_range(0, 1)) : (rel >= tc.rdy_from);
        while (done_cnt == 0 && rel < 600) begin
            @(posedge clk);
            #1;
            rel++;
            start = tc.restart && (rel == 1);
            if (start) base_addr = 42'h0BEEF00;
            c0tx_almfull = (rel >= tc.af_lo) && (rel <= tc.af_hi);
            out_ready    = tc.rdy_rand ? 1'($urandom_range(0, 1)) : (rel >= tc.rdy_from);
            if (tc.exp_hold >= 0 && rel == tc.rdy_from - 1) begin
                chk({nm, "_hold_reqs"}, 64'(req_cnt), 64'(tc.exp_hold));
                chk({nm, "_hold_out_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_hold_busy"}, 64'(busy), 64'd1);
            end
        end
        chk({nm, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        start        = 1'b0;
        c0tx_almfull = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({nm, "_issued"}, 64'(req_cnt), 64'(tc.num));
        chk({nm, "_delivered"}, 64'(pop_cnt), 64'(tc.num));
        chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
`ifdef PIPEARCH_RD_STATS_EN
        chk({nm, "_stat_issued"}, 64'(stat_issued), 64'(tc.num));
        if (tc.exp_stall >= 0) chk({nm, "_stat_stall"}, 64'(stat_stall), 64'(tc.exp_stall));
`else
        chk({nm, "_stat_issued"}, 64'(stat_issued), 64'd0);
        chk({nm, "_stat_stall"}, 64'(stat_stall), 64'd0);
`endif
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_c0tx_valid"}, 64'(c0tx_valid), 64'd0);
        chk({nm, "_c0tx_addr"}, 64'(c0tx_addr), 64'd0);
        chk({nm, "_c0tx_mdata"}, 64'(c0tx_mdata), 64'd0);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_stat_issued"}, 64'(stat_issued), 64'd0);
        chk({nm, "_stat_stall"}, 64'(stat_stall), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        //            base              num  lat af_lo af_hi rdy  rand rst hold stall
        tbl[0] = '{42'h1000,          32'd4,  2, -1, -2,  0, 1'b0, 1'b0, -1, -1};
        tbl[1] = '{42'h3FF_FFFF_FFFE, 32'd5,  3, -1, -2,  0, 1'b0, 1'b0, -1, -1};
        tbl[2] = '{42'h20,            32'd0,  2, -1, -2,  0, 1'b0, 1'b0, -1,  0};
        tbl[3] = '{42'h500,           32'd8,  1,  2,  5,  0, 1'b0, 1'b0, -1,  4};
        tbl[4] = '{42'h7000,          32'd10, 1, -1, -2, 30, 1'b0, 1'b0,  4, -1};
        tbl[5] = '{42'h9000,          32'd12, 2, -1, -2,  0, 1'b1, 1'b1, -1, -1};
        ooo_ord = '{16'd3, 16'd0, 16'd2, 16'd1};

        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_lines    = '0;
        c0tx_almfull = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_case(tbl[i], $sformatf("case%0d", i));
        end

        // Zero-length transfer: busy for exactly one cycle, done one cycle later.
        clear_run(42'h20, 2);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_lines = 32'd0;
        @(negedge clk);
        chk("zl_busy_c0", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("zl_busy_c1", 64'(busy), 64'd1);
        chk("zl_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        chk("zl_busy_c2", 64'(busy), 64'd0);
        chk("zl_done_c2", 64'(done), 64'd1);
        @(negedge clk);
        chk("zl_done_c3", 64'(done), 64'd0);
        chk("zl_no_req", 64'(req_cnt), 64'd0);
        chk("zl_done_count", 64'(done_cnt), 64'd1);

        // Responses returned out of order are delivered in arrival order.
        clear_run(42'h40, 0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 42'h40;
        num_lines = 32'd4;
        out_ready = 1'b1;
        rel = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (req_cnt < 4 && rel < 100) begin
            @(posedge clk);
            #1;
            rel++;
        end
        chk("ooo_issued", 64'(req_cnt), 64'd4);
        chk("ooo_drain_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) rsp_q.push_back('{ooo_ord[i], 0});
        rel = 0;
        while (done_cnt == 0 && rel < 100) begin
            @(posedge clk);
            #1;
            rel++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("ooo_pops", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < pop_log.size() && i < 4; i++) begin
            chk($sformatf("ooo_order%0d", i), 64'(pop_log[i]), 64'(ooo_ord[i]));
        end
        chk("ooo_done_count", 64'(done_cnt), 64'd1);
        chk("ooo_done_after_pop", 64'(done_cyc > last_pop_cyc), 64'd1);

        // Reset in the middle of a transfer aborts without done; stale responses drop.
        clear_run(42'h2000, 20);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 42'h2000;
        num_lines = 32'd6;
        rel = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (req_cnt < 3 && rel < 100) begin
            @(posedge clk);
            #1;
            rel++;
        end
        chk("rst_reached3", 64'(req_cnt >= 3), 64'd1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        chk("midrst_dropped", 64'(pop_cnt), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_rsp_drained", 64'(rsp_q.size()), 64'd0);
        run_case(tbl[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipearch_rd_streamer.md
PIPEARCH_RD_STREAMER -- requirements
Module: pipearch_rd_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 6, log2 of line buffer depth (64 lines).
REQ-002 SHALL have parameter ADDR_W, default 42, cache-line address width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start in 1 (pulse), base_addr in ADDR_W (line address), num_lines in 32 (lines to read).
REQ-006 SHALL have ports busy out 1 and done out 1 (one-cycle pulse at completion).
REQ-007 SHALL have ports c0tx_valid out 1, c0tx_addr out ADDR_W, c0tx_mdata out 16: single-line read request toward CCI-P c0Tx.
REQ-008 SHALL have port c0tx_almfull  in  1  CCI-P c0TxAlmFull.
REQ-009 SHALL have ports c0rx_valid in 1, c0rx_mdata in 16, c0rx_data in 512: read response, never back-pressured.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_data out 512, out_idx out 16: line stream.
REQ-011 SHALL have ports stat_issued out 32 and stat_stall out 32 (see Configuration).

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-013 IDLE: start=1 SHALL latch base_addr, num_lines, clear issue index; go ISSUE, or DONE if num_lines=0.
REQ-014 start SHALL be ignored outside IDLE; busy SHALL be 1 in every state except IDLE.
REQ-015 ISSUE SHALL assert c0tx_valid for one cycle per request when c0tx_almfull=0 and inflight + fifo_count < 2^FIFO_DEPTH_LOG2.
REQ-016 Request k SHALL carry c0tx_addr = base_addr + k (mod 2^ADDR_W) and c0tx_mdata = k[15:0]; at most one request per cycle.
REQ-017 ISSUE SHALL go DRAIN in the cycle after request num_lines-1 is issued.
REQ-018 DRAIN SHALL go DONE when inflight=0 and fifo_count=0; DONE SHALL pulse done for one cycle and return IDLE.
REQ-019 inflight SHALL increment on issue, decrement on c0rx_valid; simultaneous issue and response SHALL leave it unchanged.
REQ-020 Every c0rx_valid SHALL write {c0rx_mdata, c0rx_data} into the FIFO same cycle; arrival order preserved, no reordering.
REQ-021 Credit rule (REQ-015) SHALL guarantee the FIFO never overflows; a write to a full FIFO is a design error (assertion).
REQ-022 out_valid SHALL equal FIFO non-empty; a line pops when out_valid and out_ready; out_idx = stored mdata.
REQ-023 FIFO read latency SHALL be zero (first-word fall-through); simultaneous push and pop at any occupancy SHALL be legal.
REQ-024 c0tx_valid SHALL be registered; c0tx_almfull sampled in cycle N blocks issue in cycle N.

Reset
REQ-025 On reset: FSM IDLE; busy, done, c0tx_valid, out_valid = 0; c0tx_addr, c0tx_mdata, inflight, FIFO pointers, stats = 0.
REQ-026 Reset mid-transfer SHALL abort immediately without done; responses arriving after reset release SHALL be accepted into the FIFO only if busy=1, otherwise dropped.

Configuration
REQ-027 With PIPEARCH_RD_STATS_EN defined: stat_issued counts requests issued, stat_stall counts ISSUE cycles blocked by c0tx_almfull or credits; both clear on accepted start, saturate at 2^32-1.
REQ-028 Without PIPEARCH_RD_STATS_EN: stat_issued and stat_stall SHALL be constant 0 and counter logic absent.

Structure
REQ-029 State enum t_rd_streamer_state and line width constant SHALL live in shared package pipearch_common_pkg.
REQ-030 Line buffer SHALL be sub-module pipearch_line_fifo (parameterised width/depth, FWFT, count output).

Verification
REQ-031 base_addr=0x1000, num_lines=4, almfull=0, responses in order 2 cycles later, out_ready=1 -> addrs 0x1000..0x1003, mdata 0..3, out_idx 0..3, done once.
REQ-032 num_lines=0 -> no c0tx_valid, done pulses 2 cycles after start, busy high 1 cycle.
REQ-033 num_lines=8, almfull high cycles 2-5 -> no requests in those cycles, 8 total issued; with STATS_EN stat_stall=4.
REQ-034 FIFO_DEPTH_LOG2=2, num_lines=10, out_ready=0 -> issue halts at 4; out_ready=1 -> resumes, all 10 delivered.
REQ-035 Responses returned order 3,0,2,1 -> out_idx 3,0,2,1; done after last pop.
REQ-036 reset asserted after 3 of 6 issued -> all outputs 0 next edge, no done; new start after release runs cleanly.
